// File: rtl/xmss_addr_pkg.sv
// rtl/xmss_addr_pkg.sv - XMSS hash-address word layout and treehash FSM states
package xmss_addr_pkg;

    localparam int ADDR_W = 256;

    localparam int WORD_LAYER        = 0;
    localparam int WORD_TREE_HI      = 1;
    localparam int WORD_TREE_LO      = 2;
    localparam int WORD_TYPE         = 3;
    localparam int WORD_LTREE        = 4;
    localparam int WORD_TREE_HEIGHT  = 5;
    localparam int WORD_TREE_INDEX   = 6;
    localparam int WORD_KEY_AND_MASK = 7;

    localparam logic [31:0] ADDR_TYPE_HASHTREE = 32'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_HWAIT,
        ST_FIN
    } th_state_t;

    // Word 0 is the most significant 32 bits of the address.
    function automatic logic [ADDR_W-1:0] set_addr_word(input logic [ADDR_W-1:0] addr,
                                                        input int idx,
                                                        input logic [31:0] word);
        logic [ADDR_W-1:0] res;
        res = addr;
        res[ADDR_W-1-32*idx -: 32] = word;
        return res;
    endfunction

    function automatic logic [31:0] get_addr_word(input logic [ADDR_W-1:0] addr,
                                                  input int idx);
        return addr[ADDR_W-1-32*idx -: 32];
    endfunction

endpackage

// File: rtl/treehash_stack.sv
// rtl/treehash_stack.sv - height-tagged node LIFO with push and atomic pop2-push
module treehash_stack #(
    parameter int KEY_LEN = 256,
    parameter int DEPTH   = 11,
    parameter int HT_W    = 4,
    parameter int SP_W    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               push,
    input  logic               pop2_push,
    input  logic [KEY_LEN-1:0] din_node,
    input  logic [HT_W-1:0]    din_ht,
    output logic [KEY_LEN-1:0] top_node,
    output logic [HT_W-1:0]    top_ht,
    output logic [KEY_LEN-1:0] sec_node,
    output logic [HT_W-1:0]    sec_ht,
    output logic [SP_W-1:0]    sp
);

    logic [KEY_LEN-1:0] node_mem [DEPTH];
    logic [HT_W-1:0]    ht_mem   [DEPTH];
    logic [SP_W-1:0]    wr_idx;

    // A merge overwrites the left child slot with the parent.
    assign wr_idx = pop2_push ? (sp - SP_W'(2)) : sp;

    always_comb begin
        top_node = '0;
        top_ht   = '0;
        sec_node = '0;
        sec_ht   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(sp) == i + 1) begin
                top_node = node_mem[i];
                top_ht   = ht_mem[i];
            end
            if (int'(sp) == i + 2) begin
                sec_node = node_mem[i];
                sec_ht   = ht_mem[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else if (clear) begin
            sp <= '0;
        end else if (push) begin
            sp <= sp + SP_W'(1);
        end else if (pop2_push) begin
            sp <= sp - SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push || pop2_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (int'(wr_idx) == i) begin
                    node_mem[i] <= din_node;
                    ht_mem[i]   <= din_ht;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && sp >= SP_W'(DEPTH)));
            assert (!(pop2_push && sp < SP_W'(2)));
        end
    end

endmodule

// File: rtl/treehash_root.sv
// rtl/treehash_root.sv - Merkle treehash stage: stacks leaves, issues merges, presents subtree root
module treehash_root
    import xmss_addr_pkg::*;
#(
    parameter int KEY_LEN     = 256,
    parameter int TREE_HEIGHT = 10,
    parameter int STACK_DEPTH = TREE_HEIGHT + 1,
    parameter int IDX_W       = TREE_HEIGHT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [255:0]       hash_addr,
    input  logic [KEY_LEN-1:0] leaf_in,
    input  logic               leaf_valid,
    output logic               leaf_ready,
    output logic               h_start,
    output logic [KEY_LEN-1:0] h_left,
    output logic [KEY_LEN-1:0] h_right,
    output logic [255:0]       h_addr,
    input  logic               h_done,
    input  logic [KEY_LEN-1:0] h_result,
    output logic [KEY_LEN-1:0] root_out,
    output logic [255:0]       hash_addr_out,
    output logic               done,
    output logic               busy
);

    localparam int HT_W = $clog2(TREE_HEIGHT + 1);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((1 << TREE_HEIGHT) - 1);

    th_state_t state, next_state;

    logic [IDX_W-1:0]   leaf_idx;
    logic [255:0]       base_addr;
    logic [255:0]       merge_addr;
    logic               stk_clear, stk_push, stk_pop2;
    logic               issue, advance, finish, merge_ok;
    logic [KEY_LEN-1:0] top_node, sec_node, din_node;
    logic [HT_W-1:0]    top_ht, sec_ht, din_ht;
    logic [SP_W-1:0]    sp;

    assign merge_ok = (sp >= SP_W'(2)) && (top_ht == sec_ht);
    assign din_node = stk_pop2 ? h_result : leaf_in;
    assign din_ht   = stk_pop2 ? (top_ht + HT_W'(1)) : '0;
    assign busy     = (state != ST_IDLE) || done;

    treehash_stack #(
        .KEY_LEN(KEY_LEN),
        .DEPTH  (STACK_DEPTH),
        .HT_W   (HT_W),
        .SP_W   (SP_W)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .clear    (stk_clear),
        .push     (stk_push),
        .pop2_push(stk_pop2),
        .din_node (din_node),
        .din_ht   (din_ht),
        .top_node (top_node),
        .top_ht   (top_ht),
        .sec_node (sec_node),
        .sec_ht   (sec_ht),
        .sp       (sp)
    );

    always_comb begin
        merge_addr = '0;
        merge_addr = set_addr_word(merge_addr, WORD_LAYER, get_addr_word(base_addr, WORD_LAYER));
        merge_addr = set_addr_word(merge_addr, WORD_TREE_HI, get_addr_word(base_addr, WORD_TREE_HI));
        merge_addr = set_addr_word(merge_addr, WORD_TREE_LO, get_addr_word(base_addr, WORD_TREE_LO));
        merge_addr = set_addr_word(merge_addr, WORD_TYPE, ADDR_TYPE_HASHTREE);
        merge_addr = set_addr_word(merge_addr, WORD_LTREE, 32'd0);
        merge_addr = set_addr_word(merge_addr, WORD_TREE_HEIGHT, 32'(top_ht));
        merge_addr = set_addr_word(merge_addr, WORD_TREE_INDEX,
                                   32'(leaf_idx) >> (32'(top_ht) + 32'd1));
        merge_addr = set_addr_word(merge_addr, WORD_KEY_AND_MASK, 32'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        leaf_ready = 1'b0;
        stk_clear  = 1'b0;
        stk_push   = 1'b0;
        stk_pop2   = 1'b0;
        issue      = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                // The done cycle still counts as busy, so a start there is dropped.
                if (start && !done) begin
                    stk_clear  = 1'b1;
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                leaf_ready = 1'b1;
                if (leaf_valid) begin
                    stk_push   = 1'b1;
                    next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (merge_ok) begin
                    issue      = 1'b1;
                    next_state = ST_HWAIT;
                end else if (leaf_idx == LAST_IDX) begin
                    next_state = ST_FIN;
                end else begin
                    advance    = 1'b1;
                    next_state = ST_LOAD;
                end
            end
            ST_HWAIT: begin
                if (h_done) begin
                    stk_pop2   = 1'b1;
                    next_state = ST_CHECK;
                end
            end
            ST_FIN: begin
                finish     = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leaf_idx      <= '0;
            base_addr     <= '0;
            h_start       <= 1'b0;
            h_left        <= '0;
            h_right       <= '0;
            h_addr        <= '0;
            hash_addr_out <= '0;
            root_out      <= '0;
            done          <= 1'b0;
        end else begin
            h_start <= issue;
            done    <= finish;
            if (stk_clear) begin
                leaf_idx  <= '0;
                base_addr <= hash_addr;
            end else if (advance) begin
                leaf_idx <= leaf_idx + IDX_W'(1);
            end
            if (issue) begin
                h_left  <= sec_node;
                h_right <= top_node;
                h_addr  <= merge_addr;
            end
            if (stk_pop2) begin
                hash_addr_out <= h_addr;
            end
            if (finish) begin
                root_out <= top_node;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state == ST_FIN) begin
            assert (sp == SP_W'(1) && top_ht == HT_W'(TREE_HEIGHT));
        end
    end

endmodule

// File: tb/tb_treehash_root.sv
// tb/tb_treehash_root.sv - treehash_root bench against a level-order Merkle tree model
module tb_treehash_root;

    localparam int KL = 256;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [255:0] base_addr = '0;

    logic start2 = 1'b0, poke2 = 1'b0, lv2 = 1'b0, hd2 = 1'b0, stray2 = 1'b0;
    logic [KL-1:0] ld2 = '0, hr2 = '0;
    logic lr2, hs2, dn2, bz2;
    logic [KL-1:0] hl2, hrt2, ro2;
    logic [255:0] ha2, hao2;

    logic start10 = 1'b0, lv10 = 1'b0, hd10 = 1'b0;
    logic [KL-1:0] ld10 = '0, hr10 = '0;
    logic lr10, hs10, dn10, bz10;
    logic [KL-1:0] hl10, hrt10, ro10;
    logic [255:0] ha10, hao10;

    treehash_root #(.KEY_LEN(KL), .TREE_HEIGHT(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2 | poke2), .hash_addr(base_addr),
        .leaf_in(ld2), .leaf_valid(lv2), .leaf_ready(lr2), .h_start(hs2),
        .h_left(hl2), .h_right(hrt2), .h_addr(ha2), .h_done(hd2 | stray2),
        .h_result(hr2), .root_out(ro2), .hash_addr_out(hao2), .done(dn2), .busy(bz2)
    );

    treehash_root #(.KEY_LEN(KL), .TREE_HEIGHT(10)) u_dut10 (
        .clk(clk), .reset(reset), .start(start10), .hash_addr(base_addr),
        .leaf_in(ld10), .leaf_valid(lv10), .leaf_ready(lr10), .h_start(hs10),
        .h_left(hl10), .h_right(hrt10), .h_addr(ha10), .h_done(hd10),
        .h_result(hr10), .root_out(ro10), .hash_addr_out(hao10), .done(dn10), .busy(bz10)
    );

    int hmode = 0;
    int hdelay = 0;
    bit poke_en = 1'b0;
    int pend2 = 0, cnt2 = 0, nhs2 = 0, unstable = 0, extra = 0;
    int nhs10 = 0, max_sp10 = 0;
    logic [255:0] cap_l, cap_r, cap_a;
    logic [255:0] addr_q[$];
    logic [255:0] leaves[1024];
    logic [255:0] ref_root, ref_last_addr;

    function automatic logic [255:0] hashf(input logic [255:0] l, input logic [255:0] r,
                                           input logic [255:0] a, input int mode);
        if (mode == 0) return l ^ r;
        return ({l[248:0], l[255:249]} + (r * 256'd3)) ^ a ^ {a[127:0], a[255:128]};
    endfunction

    function automatic logic [255:0] mk_addr(input logic [255:0] b, input int h, input int i);
        return {b[255:160], 32'd2, 32'd0, 32'(h), 32'(i), 32'd0};
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v = {v[223:0], 32'($urandom)};
        return v;
    endfunction

    // Tree built level by level: node(h+1, i) = H(node(h, 2i), node(h, 2i+1)) at address (h, i).
    task automatic ref_tree(input int ht, input int mode);
        logic [255:0] lvl[1024];
        for (int i = 0; i < (1 << ht); i++) lvl[i] = leaves[i];
        for (int h = 0; h < ht; h++) begin
            for (int i = 0; i < (1 << (ht - h - 1)); i++) begin
                ref_last_addr = mk_addr(base_addr, h, i);
                lvl[i] = hashf(lvl[2*i], lvl[2*i+1], ref_last_addr, mode);
            end
        end
        ref_root = lvl[0];
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hash-unit responders for both instances.
    initial forever begin
        @(negedge clk);
        hd2 = 1'b0;
        poke2 = 1'b0;
        hd10 = 1'b0;
        if (reset) begin
            pend2 = 0;
        end else begin
            if (pend2 != 0 && (hl2 !== cap_l || hrt2 !== cap_r || ha2 !== cap_a)) unstable++;
            if (hs2) begin
                if (pend2 != 0) extra++;
                cap_l = hl2;
                cap_r = hrt2;
                cap_a = ha2;
                pend2 = 1;
                cnt2 = hdelay;
                nhs2++;
                addr_q.push_back(ha2);
            end
            if (pend2 != 0) begin
                if (poke_en && cnt2 == 5) poke2 = 1'b1;
                if (cnt2 == 0) begin
                    hd2 = 1'b1;
                    hr2 = hashf(cap_l, cap_r, cap_a, hmode);
                    pend2 = 0;
                end else begin
                    cnt2--;
                end
            end
            if (hs10) begin
                hd10 = 1'b1;
                hr10 = hashf(hl10, hrt10, ha10, hmode);
                nhs10++;
            end
            if (int'(u_dut10.u_stack.sp) > max_sp10) max_sp10 = int'(u_dut10.u_stack.sp);
        end
    end

    task automatic start2_pulse();
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic feed_one(input logic [255:0] v, input int gap, input bit stray);
        int n;
        n = 0;
        @(negedge clk);
        while (!lr2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!lr2) check("leaf_ready_wait", lr2, 1);
        for (int g = 0; g < gap; g++) begin
            if (stray && g == 3) stray2 = 1'b1;
            @(negedge clk);
            stray2 = 1'b0;
        end
        lv2 = 1'b1;
        ld2 = v;
        @(negedge clk);
        lv2 = 1'b0;
    endtask

    task automatic wait_done2(input string tag);
        int n;
        n = 0;
        while (!dn2 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, dn2, 1);
    endtask

    task automatic run2(input int gap, input bit stray, input string tag);
        nhs2 = 0;
        addr_q.delete();
        start2_pulse();
        for (int i = 0; i < 4; i++) feed_one(leaves[i], gap, stray);
        wait_done2(tag);
    endtask

    initial begin
        int n;
        int exp_h[3];
        int exp_i[3];
        logic [255:0] tmp;
        exp_h = '{0, 0, 1};
        exp_i = '{0, 1, 0};

        repeat (3) @(negedge clk);
        check("rst_leaf_ready", lr2, 0);
        check("rst_h_start", hs2, 0);
        check("rst_done", dn2, 0);
        check("rst_busy", bz2, 0);
        check("rst_root", ro2, 0);
        check("rst_h_left", hl2, 0);
        check("rst_h_addr", ha2, 0);
        check("rst_hash_addr_out", hao2, 0);
        reset = 1'b0;

        // XOR model, leaves 1..4
        hmode = 0;
        hdelay = 0;
        base_addr = rand256();
        for (int i = 0; i < 4; i++) leaves[i] = 256'(i + 1);
        ref_tree(2, 0);
        nhs2 = 0;
        addr_q.delete();
        start2_pulse();
        check("xor_busy_after_start", bz2, 1);
        for (int i = 0; i < 4; i++) feed_one(leaves[i], 0, 1'b0);
        wait_done2("xor");
        check("xor_root", ro2, 256'd4);
        check("xor_busy_in_done", bz2, 1);
        check("xor_hash_addr_out", hao2, ref_last_addr);
        check("xor_h_starts", nhs2, 3);
        check("xor_addr_count", addr_q.size(), 3);
        for (int k = 0; k < 3 && k < addr_q.size(); k++) begin
            tmp = addr_q[k];
            check("xor_merge_addr", tmp, mk_addr(base_addr, exp_h[k], exp_i[k]));
        end
        @(negedge clk);
        check("xor_done_one_cycle", dn2, 0);
        check("xor_busy_drop", bz2, 0);
        check("xor_root_held", ro2, 256'd4);

        // Randomized hash model and random leaves
        hmode = 1;
        hdelay = $urandom_range(0, 3);
        base_addr = rand256();
        for (int i = 0; i < 4; i++) leaves[i] = rand256();
        ref_tree(2, 1);
        run2(0, 1'b0, "rnd");
        check("rnd_root", ro2, ref_root);
        check("rnd_hash_addr_out", hao2, ref_last_addr);
        tmp = hao2;
        check("rnd_w5_w6", tmp[95:32], 64'h0000_0001_0000_0000);

        // Slow leaves and slow hash
        hdelay = 100;
        unstable = 0;
        extra = 0;
        run2(20, 1'b0, "slow");
        check("slow_root", ro2, ref_root);
        check("slow_h_starts", nhs2, 3);
        check("slow_stable", unstable, 0);
        check("slow_no_extra", extra, 0);

        // start during HWAIT, stray h_done during LOAD
        hdelay = 20;
        poke_en = 1'b1;
        extra = 0;
        run2(6, 1'b1, "poke");
        poke_en = 1'b0;
        check("poke_root", ro2, ref_root);
        check("poke_h_starts", nhs2, 3);
        check("poke_no_extra", extra, 0);

        // Reset in the middle of a hash wait
        hdelay = 50;
        start2_pulse();
        feed_one(leaves[0], 0, 1'b0);
        feed_one(leaves[1], 0, 1'b0);
        n = 0;
        while (pend2 == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_in_hwait", pend2, 1);
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rstmid_busy", bz2, 0);
        check("rstmid_leaf_ready", lr2, 0);
        check("rstmid_root", ro2, 0);
        check("rstmid_h_left", hl2, 0);
        check("rstmid_h_right", hrt2, 0);
        check("rstmid_h_addr", ha2, 0);
        check("rstmid_hash_addr_out", hao2, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        hmode = 0;
        hdelay = 1;
        for (int i = 0; i < 4; i++) leaves[i] = 256'(i + 5);
        run2(0, 1'b0, "after_rst");
        check("after_rst_root", ro2, 256'd12);
        check("after_rst_h_starts", nhs2, 3);

        // Full H=10 tree
        hmode = 1;
        base_addr = rand256();
        for (int i = 0; i < 1024; i++) leaves[i] = rand256();
        ref_tree(10, 1);
        nhs10 = 0;
        max_sp10 = 0;
        @(negedge clk);
        start10 = 1'b1;
        @(negedge clk);
        start10 = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            n = 0;
            while (!lr10 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            if (!lr10) begin
                check("full_leaf_ready_wait", lr10, 1);
                break;
            end
            lv10 = 1'b1;
            ld10 = leaves[i];
            @(negedge clk);
            lv10 = 1'b0;
        end
        n = 0;
        while (!dn10 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("full_done", dn10, 1);
        check("full_root", ro10, ref_root);
        check("full_hash_addr_out", hao10, ref_last_addr);
        check("full_h_starts", nhs10, 1023);
        check("full_max_sp", max_sp10, 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
